fifo_enq_arbiter: RTL and testbench

Round-robin arbiter that shares the enqueue port of the team's FIFO between N_REQ producers. Each producer uses the irdy/trdy handshake. The arbiter holds a registered grant for a burst of up to MAX_BURST transfers, then rotates. It sits directly in front of the FIFO's p2f_irdy/data_in/f2p_trdy interface. The FIFO's existing checker keeps observing that interface unchanged.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_enq_arbiter_rr_picker.sv | 30 +++
 rtl/fifo_enq_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_enq_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO enqueue path: default payload shape and arbiter FSM states.
package fifo_pkg;

   localparam int FIFO_T_SIZE = 3;

   typedef logic [FIFO_T_SIZE-1:0] t_payload;

   typedef enum logic {
      IDLE,
      GRANT
   } t_arb_state;

endpackage

// File: rtl/fifo_enq_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit scanning last+1, last+2, ... modulo N_REQ.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int LOG_N = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [LOG_N-1:0] last,
   output logic [LOG_N-1:0] pick,
   output logic             any
);

   int unsigned idx;

   // Wrap by compare-and-subtract so non-power-of-2 N_REQ never aliases onto a missing producer.
   always_comb begin
      pick = last;
      any  = 1'b0;
      idx  = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = 32'(last) + i;
         if (idx >= N_REQ)
            idx = idx - 32'(N_REQ);
         if (!any && req[idx]) begin
            any  = 1'b1;
            pick = LOG_N'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing the FIFO enqueue port between N_REQ irdy/trdy producers,
// holding each grant for a burst of up to MAX_BURST transfers.
module fifo_enq_arbiter
   import fifo_pkg::*;
#(
   parameter int  N_REQ     = 4,
   parameter int  T_SIZE    = FIFO_T_SIZE,
   parameter type T         = logic [T_SIZE-1:0],
   parameter int  MAX_BURST = 4,
   parameter int  LOG_N     = $clog2(N_REQ),
   parameter int  LOG_BURST = $clog2(MAX_BURST+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] p2a_irdy,
   input  T                 p2a_data [N_REQ],
   output logic [N_REQ-1:0] a2p_trdy,
   input  logic [N_REQ-1:0] req_en,
   output logic             p2f_irdy,
   output T                 data_in,
   input  logic             f2p_trdy,
   output logic             gnt_valid,
   output logic [LOG_N-1:0] gnt_idx
);

   t_arb_state           state_q, state_d;
   logic [LOG_N-1:0]     gnt_idx_q, gnt_idx_d;
   logic [LOG_BURST-1:0] burst_cnt_q, burst_cnt_d;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] req_others;
   logic [N_REQ-1:0] req_next;
   logic [N_REQ-1:0] pick_req;
   logic             cur_req;
   logic             enq;
   logic             burst_done;
   logic             release_gnt;
   logic [LOG_N-1:0] pick;
   logic             any;

   always_comb begin
      req       = p2a_irdy & req_en;
      gnt_valid = (state_q == GRANT);
      cur_req   = req[gnt_idx_q];
      p2f_irdy  = gnt_valid & cur_req;
      enq       = p2f_irdy & f2p_trdy;
   end

   always_comb begin
      data_in  = '0;
      a2p_trdy = '0;
      if (gnt_valid) begin
         data_in = p2a_data[gnt_idx_q];
         if (cur_req && f2p_trdy)
            a2p_trdy[gnt_idx_q] = 1'b1;
      end
   end

   assign gnt_idx = gnt_idx_q;

   // A burst-limit release skips the current holder when anyone else waits; a lone
   // requester keeps its bit so the scan wraps back onto it for an immediate re-grant.
   always_comb begin
      burst_done  = enq && (burst_cnt_q == LOG_BURST'(MAX_BURST-1));
      release_gnt = !cur_req || burst_done;
      req_others  = req;
      req_others[gnt_idx_q] = 1'b0;
      req_next    = (burst_done && |req_others) ? req_others : req;
      pick_req    = gnt_valid ? req_next : req;
   end

   rr_picker #(
      .N_REQ (N_REQ),
      .LOG_N (LOG_N)
   ) u_rr_picker (
      .req  (pick_req),
      .last (gnt_idx_q),
      .pick (pick),
      .any  (any)
   );

   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               state_d     = GRANT;
               gnt_idx_d   = pick;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (release_gnt) begin
               if (any) begin
                  gnt_idx_d   = pick;
                  burst_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (enq) begin
               burst_cnt_d = burst_cnt_q + LOG_BURST'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_idx_q   <= LOG_N'(N_REQ-1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_idx_q   <= gnt_idx_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   a_trdy_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(a2p_trdy));
   a_enq_onehot   : assert property (@(posedge clk) disable iff (!rst) enq |-> $onehot(a2p_trdy));
   a_burst_bound  : assert property (@(posedge clk) disable iff (!rst) burst_cnt_q < LOG_BURST'(MAX_BURST));

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Self-checking bench for fifo_enq_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural round-robin/burst model.
module tb_fifo_enq_arbiter;

   localparam int N  = 4;
   localparam int TS = 3;
   localparam int MB = 4;
   localparam int LN = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  p2a_irdy = '0;
   logic [TS-1:0] p2a_data [N];
   logic [N-1:0]  a2p_trdy;
   logic [N-1:0]  req_en = '1;
   logic          p2f_irdy;
   logic [TS-1:0] data_in;
   logic          f2p_trdy = 1'b0;
   logic          gnt_valid;
   logic [LN-1:0] gnt_idx;

   logic [10:0] obs;
   logic [10:0] exp_v;
   assign obs = {p2f_irdy, a2p_trdy, data_in, gnt_valid, gnt_idx};

   int checks   = 0;
   int failures = 0;

   bit m_grant;
   int m_g;
   int m_cnt;
   int m_sent [N];
   int d_sent [N];

   always #5 clk = ~clk;

   fifo_enq_arbiter #(
      .N_REQ     (N),
      .T_SIZE    (TS),
      .MAX_BURST (MB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .p2a_irdy  (p2a_irdy),
      .p2a_data  (p2a_data),
      .a2p_trdy  (a2p_trdy),
      .req_en    (req_en),
      .p2f_irdy  (p2f_irdy),
      .data_in   (data_in),
      .f2p_trdy  (f2p_trdy),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   function automatic int rr(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [10:0] model_out();
      logic [N-1:0]  r;
      logic          v;
      logic [N-1:0]  t;
      logic [TS-1:0] d;
      r = p2a_irdy & req_en;
      v = 1'b0;
      t = '0;
      d = '0;
      if (m_grant) begin
         v = r[m_g];
         d = p2a_data[m_g];
         if (v && f2p_trdy) t[m_g] = 1'b1;
      end
      return {v, t, d, m_grant, LN'(m_g)};
   endfunction

   task automatic model_reset();
      m_grant = 1'b0;
      m_g     = N - 1;
      m_cnt   = 0;
   endtask

   task automatic model_tick();
      logic [N-1:0] r;
      logic [N-1:0] rn;
      logic [N-1:0] others;
      bit           enq, lim;
      int           p;
      r = p2a_irdy & req_en;
      if (!m_grant) begin
         p = rr(r, m_g);
         if (p >= 0) begin
            m_grant = 1'b1;
            m_g     = p;
            m_cnt   = 0;
         end
      end else begin
         enq = r[m_g] && f2p_trdy;
         lim = enq && (m_cnt == MB - 1);
         if (enq) begin
            m_cnt++;
            m_sent[m_g]++;
         end
         if (!r[m_g] || lim) begin
            others = r;
            others[m_g] = 1'b0;
            rn = (lim && others != '0) ? others : r;
            p = rr(rn, m_g);
            if (p >= 0) begin
               m_g   = p;
               m_cnt = 0;
            end else begin
               m_grant = 1'b0;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_tick();
      #1;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) p2a_data[i] = TS'($urandom);
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      p2a_irdy = '0;
      req_en   = '1;
      f2p_trdy = 1'b0;
      rand_data();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== 11'b0_0000_000_0_11) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected %b", obs, 11'b0_0000_000_0_11);
      end
      cycle();
      rst = 1'b1;
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL reset_idle: got %b expected %b", obs, exp_v);
      end
      cycle();
   endtask

   task automatic test_single();
      do_reset();
      f2p_trdy = 1'b1;
      p2a_irdy = 4'b0100;
      for (int it = 0; it < 12; it++) begin
         rand_data();
         p2a_data[2] = 3'd5;
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL single_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         checks++;
         if (it == 0 && gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: got gnt_valid=%b expected 0", gnt_valid);
         end else if (it > 0 && {gnt_valid, gnt_idx, p2f_irdy, data_in, a2p_trdy} !== {1'b1, 2'd2, 1'b1, 3'd5, 4'b0100}) begin
            failures++;
            $display("FAIL single_stream it%0d: got %b expected %b", it,
                     {gnt_valid, gnt_idx, p2f_irdy, data_in, a2p_trdy}, {1'b1, 2'd2, 1'b1, 3'd5, 4'b0100});
         end
         cycle();
      end
   endtask

   task automatic test_all_rr();
      do_reset();
      f2p_trdy = 1'b1;
      p2a_irdy = 4'b1111;
      for (int it = 0; it < 18; it++) begin
         rand_data();
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL rr_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         if (it >= 1) begin
            checks++;
            if (!(p2f_irdy && f2p_trdy) || gnt_idx !== LN'(((it - 1) / MB) % N)) begin
               failures++;
               $display("FAIL rr_order it%0d: got enq=%b idx=%0d expected enq=1 idx=%0d",
                        it, p2f_irdy && f2p_trdy, gnt_idx, ((it - 1) / MB) % N);
            end
         end
         cycle();
      end
   endtask

   task automatic test_full_hold();
      logic [TS-1:0] d1;
      do_reset();
      d1 = TS'($urandom);
      f2p_trdy = 1'b1;
      p2a_irdy = 4'b0010;
      for (int it = 0; it < 17; it++) begin
         if (it == 2) begin
            f2p_trdy = 1'b0;
            p2a_irdy = 4'b1010;
         end
         if (it == 12) f2p_trdy = 1'b1;
         rand_data();
         p2a_data[1] = d1;
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL hold_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         if (it >= 2 && it < 12) begin
            checks++;
            if ({p2f_irdy, gnt_idx, data_in, a2p_trdy} !== {1'b1, 2'd1, d1, 4'b0000}) begin
               failures++;
               $display("FAIL hold_stall it%0d: got %b expected %b", it,
                        {p2f_irdy, gnt_idx, data_in, a2p_trdy}, {1'b1, 2'd1, d1, 4'b0000});
            end
         end else if (it >= 12) begin
            checks++;
            if (!p2f_irdy || gnt_idx !== ((it < 15) ? 2'd1 : 2'd3)) begin
               failures++;
               $display("FAIL hold_resume it%0d: got irdy=%b idx=%0d expected irdy=1 idx=%0d",
                        it, p2f_irdy, gnt_idx, (it < 15) ? 1 : 3);
            end
         end
         cycle();
      end
   endtask

   task automatic test_drop();
      do_reset();
      f2p_trdy = 1'b1;
      p2a_irdy = 4'b1000;
      for (int it = 0; it < 9; it++) begin
         if (it == 1) p2a_irdy = 4'b1001;
         if (it == 3) p2a_irdy = 4'b0001;
         rand_data();
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL drop_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         if (it == 3) begin
            checks++;
            if ({gnt_valid, gnt_idx, p2f_irdy, a2p_trdy} !== {1'b1, 2'd3, 1'b0, 4'b0000}) begin
               failures++;
               $display("FAIL drop_release: got %b expected %b",
                        {gnt_valid, gnt_idx, p2f_irdy, a2p_trdy}, {1'b1, 2'd3, 1'b0, 4'b0000});
            end
         end
         if (it == 4) begin
            checks++;
            if ({gnt_valid, gnt_idx, p2f_irdy, a2p_trdy} !== {1'b1, 2'd0, 1'b1, 4'b0001}) begin
               failures++;
               $display("FAIL drop_regrant: got %b expected %b",
                        {gnt_valid, gnt_idx, p2f_irdy, a2p_trdy}, {1'b1, 2'd0, 1'b1, 4'b0001});
            end
         end
         cycle();
      end
   endtask

   task automatic test_mask();
      int order [3] = '{0, 1, 3};
      do_reset();
      req_en   = 4'b1011;
      f2p_trdy = 1'b1;
      p2a_irdy = 4'b1111;
      for (int it = 0; it < 14; it++) begin
         rand_data();
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL mask_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         if (it >= 1) begin
            checks++;
            if (gnt_idx !== LN'(order[((it - 1) / MB) % 3]) || a2p_trdy[2] !== 1'b0) begin
               failures++;
               $display("FAIL mask_order it%0d: got idx=%0d trdy=%b expected idx=%0d",
                        it, gnt_idx, a2p_trdy, order[((it - 1) / MB) % 3]);
            end
         end
         cycle();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      f2p_trdy = 1'b1;
      p2a_irdy = 4'b1111;
      for (int it = 0; it < 3; it++) begin
         rand_data();
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL midrst_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         cycle();
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== 11'b0_0000_000_0_11) begin
         failures++;
         $display("FAIL midrst_async: got %b expected %b", obs, 11'b0_0000_000_0_11);
      end
      p2a_irdy = 4'b0110;
      cycle();
      rst = 1'b1;
      for (int it = 0; it < 2; it++) begin
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL midrst_after it%0d: got %b expected %b", it, obs, exp_v);
         end
         if (it == 1) begin
            checks++;
            if ({gnt_valid, gnt_idx} !== {1'b1, 2'd1}) begin
               failures++;
               $display("FAIL midrst_first_pick: got %b expected %b", {gnt_valid, gnt_idx}, {1'b1, 2'd1});
            end
         end
         cycle();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < N; i++) begin
         m_sent[i] = 0;
         d_sent[i] = 0;
      end
      for (int it = 0; it < 600; it++) begin
         if (it % 60 == 0) req_en = 4'($urandom) | 4'($urandom);
         p2a_irdy = 4'($urandom) | 4'($urandom);
         f2p_trdy = ($urandom % 4) != 0;
         rand_data();
         @(negedge clk);
         exp_v = model_out();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL rand_model it%0d: got %b expected %b", it, obs, exp_v);
         end
         checks++;
         if (!$onehot0(a2p_trdy) || ((p2f_irdy && f2p_trdy) && !$onehot(a2p_trdy))) begin
            failures++;
            $display("FAIL rand_onehot it%0d: got trdy=%b enq=%b expected single accept",
                     it, a2p_trdy, p2f_irdy && f2p_trdy);
         end
         for (int i = 0; i < N; i++) d_sent[i] += int'(a2p_trdy[i]);
         cycle();
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (d_sent[i] !== m_sent[i]) begin
            failures++;
            $display("FAIL rand_count p%0d: got %0d expected %0d", i, d_sent[i], m_sent[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) p2a_data[i] = '0;
      test_reset();
      test_single();
      test_all_rr();
      test_full_hold();
      test_drop();
      test_mask();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
